// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
//
// Shared definitions for the multi-cycle MIPS control unit and its helpers:
//   - opcode (IR[31:26]) and R-type funct (IR[5:0]) codes
//   - ALU operation codes driven on ALUop
//   - immediate extension selects (Ext) and next-PC selects (PCSrc)
//   - controller state encodings (state_t)
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN adds the S_TRAP state encoding.
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

    // Opcodes
    localparam logic [5:0] R_OP    = 6'h00;
    localparam logic [5:0] J_OP    = 6'h02;
    localparam logic [5:0] JAL_OP  = 6'h03;
    localparam logic [5:0] BEQ_OP  = 6'h04;
    localparam logic [5:0] ADDI_OP = 6'h08;
    localparam logic [5:0] LW_OP   = 6'h23;
    localparam logic [5:0] SW_OP   = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    // ALU operation codes; ALU_NOP is reserved for "no operation / unknown"
    // and is never produced by a recognised funct.
    localparam int         ALU_CODE_W = 5;
    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_ADDU = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_SUBU = 5'd4;
    localparam logic [4:0] ALU_AND  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_XOR  = 5'd7;
    localparam logic [4:0] ALU_NOR  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;
    localparam logic [4:0] ALU_SLL  = 5'd11;
    localparam logic [4:0] ALU_SRL  = 5'd12;
    localparam logic [4:0] ALU_SRA  = 5'd13;

    // Immediate extension selects
    localparam logic [1:0] EXT_ZERO   = 2'd0;
    localparam logic [1:0] EXT_SIGNED = 2'd1;

    // Next-PC selects
    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JAL    = 2'd3;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
`ifdef ILLEGAL_OP_TRAP_EN
        S_JAL      = 4'd12,
        S_TRAP     = 4'd13
`else
        S_JAL      = 4'd12
`endif
    } state_t;

endpackage

// File: rtl/multicycle_control_alu.sv
// ---------------------------------------------------------------------------
// alu_decoder
//
// Combinational R-type funct -> ALU operation lookup. Kept separate so a
// later pipelined control unit can reuse it unchanged.
//
// Ports:
//   funct  in   6        IR[5:0]
//   alu_op out  ALUOP_W  ALU operation code (ALU_NOP for unknown funct)
// ---------------------------------------------------------------------------
module alu_decoder
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W = 5
) (
    input  logic [5:0]         funct,
    output logic [ALUOP_W-1:0] alu_op
);

    logic [ALU_CODE_W-1:0] code;

    // Variable shifts share the ALU shifter with the constant-shift forms;
    // the datapath picks the shift amount source, not the ALU.
    always_comb begin
        code = ALU_NOP;
        case (funct)
            F_SLL, F_SLLV: code = ALU_SLL;
            F_SRL, F_SRLV: code = ALU_SRL;
            F_SRA, F_SRAV: code = ALU_SRA;
            F_ADD:         code = ALU_ADD;
            F_ADDU:        code = ALU_ADDU;
            F_SUB:         code = ALU_SUB;
            F_SUBU:        code = ALU_SUBU;
            F_AND:         code = ALU_AND;
            F_OR:          code = ALU_OR;
            F_XOR:         code = ALU_XOR;
            F_NOR:         code = ALU_NOR;
            F_SLT:         code = ALU_SLT;
            F_SLTU:        code = ALU_SLTU;
            default:       code = ALU_NOP;
        endcase
    end

    assign alu_op = ALUOP_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle MIPS control FSM. Steps each instruction through
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK and drives the datapath
// strobes from the registered state. Memory accesses wait on mem_ready.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   op, funct               IR[31:26], IR[5:0]
//   mem_ready               shared memory finishes the access this cycle
//   PCWrite, PCWriteCond    PC load (unconditional / on ALU zero)
//   IorD                    memory address select: 0 PC, 1 ALUOut
//   MemRead, MemWrite       memory requests
//   IRWrite                 IR load
//   RegDst, MemtoReg        register write address / data selects
//   RegWrite                register file write enable
//   ALUSrcA, ALUSrcB        ALU operand selects
//   ALUop                   ALU operation code
//   Ext                     immediate extension select
//   PCSrc                   next-PC select
//   illegal_op              (ILLEGAL_OP_TRAP_EN only) trap indicator
//   state_o                 current state, for debug
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN. When defined, unlisted opcodes
// and unknown R-type functs park the FSM in S_TRAP until reset; otherwise
// they behave as NOPs.
// ---------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W = 5,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [1:0]         Ext,
    output logic [1:0]         PCSrc,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [STATE_W-1:0] state_o
);

    state_t             state;
    state_t             next_state;
    logic [ALUOP_W-1:0] funct_alu_op;

    alu_decoder #(
        .ALUOP_W (ALUOP_W)
    ) u_alu_decoder (
        .funct  (funct),
        .alu_op (funct_alu_op)
    );

    // State register; reset drops any in-flight instruction back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    assign state_o = STATE_W'(state);

    // Next state and strobes. Strobes are also gated by rst_n so that a
    // pending memory request is withdrawn the moment reset is asserted,
    // not at the next clock edge.
    always_comb begin
        next_state  = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 2'd0;
        MemtoReg    = 2'd0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUop       = ALUOP_W'(ALU_NOP);
        Ext         = EXT_ZERO;
        PCSrc       = NPC_PLUS4;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_op  = 1'b0;
`endif
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    MemRead    = 1'b1;
                    ALUSrcB    = 2'd1;
                    ALUop      = ALUOP_W'(ALU_ADD);
                    PCWrite    = mem_ready;
                    IRWrite    = mem_ready;
                    next_state = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    // ALU precomputes PC+4 + (imm << 2) for a possible branch
                    ALUSrcB = 2'd3;
                    Ext     = EXT_SIGNED;
                    ALUop   = ALUOP_W'(ALU_ADD);
                    case (op)
                        R_OP: begin
                            next_state = S_EXEC_R;
`ifdef ILLEGAL_OP_TRAP_EN
                            if (funct_alu_op == ALUOP_W'(ALU_NOP)) begin
                                next_state = S_TRAP;
                            end
`endif
                        end
                        ADDI_OP:      next_state = S_EXEC_I;
                        LW_OP, SW_OP: next_state = S_MEM_ADDR;
                        BEQ_OP:       next_state = S_BRANCH;
                        J_OP:         next_state = S_JUMP;
                        JAL_OP:       next_state = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                        default:      next_state = S_TRAP;
`else
                        default:      next_state = S_FETCH;
`endif
                    endcase
                end
                S_EXEC_R: begin
                    ALUSrcA    = 1'b1;
                    ALUop      = funct_alu_op;
                    next_state = S_WB_R;
                end
                S_WB_R: begin
                    RegDst     = 2'd1;
                    RegWrite   = 1'b1;
                    next_state = S_FETCH;
                end
                S_EXEC_I: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'd2;
                    Ext        = EXT_SIGNED;
                    ALUop      = ALUOP_W'(ALU_ADD);
                    next_state = S_WB_I;
                end
                S_WB_I: begin
                    RegWrite   = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEM_ADDR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'd2;
                    Ext        = EXT_SIGNED;
                    ALUop      = ALUOP_W'(ALU_ADD);
                    next_state = (op == LW_OP) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    MemRead    = 1'b1;
                    IorD       = 1'b1;
                    next_state = mem_ready ? S_WB_MEM : S_MEM_RD;
                end
                S_MEM_WR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    next_state = mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_WB_MEM: begin
                    MemtoReg   = 2'd1;
                    RegWrite   = 1'b1;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUop       = ALUOP_W'(ALU_SUB);
                    PCWriteCond = 1'b1;
                    PCSrc       = NPC_BRANCH;
                    next_state  = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSrc      = NPC_JUMP;
                    next_state = S_FETCH;
                end
                S_JAL: begin
                    // PC already holds PC+4 here, which is the link value
                    PCWrite    = 1'b1;
                    PCSrc      = NPC_JAL;
                    RegWrite   = 1'b1;
                    RegDst     = 2'd2;
                    MemtoReg   = 2'd2;
                    next_state = S_FETCH;
                end
`ifdef ILLEGAL_OP_TRAP_EN
                S_TRAP: begin
                    illegal_op = 1'b1;
                    next_state = S_TRAP;
                end
`endif
                default: next_state = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
// Self-checking bench for multicycle_control: a table of instruction vectors
// with expected totals, hand-written reset/illegal-op sequences, and a
// randomized instruction stream compared cycle-by-cycle against a
// behavioural model that lists the expected strobes of each step.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int ALUOP_W = 5;
    localparam int STATE_W = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               mem_ready;
    logic               PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0]         RegDst, MemtoReg;
    logic               RegWrite, ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUop;
    logic [1:0]         Ext, PCSrc;
    logic [STATE_W-1:0] state_o;
`ifdef ILLEGAL_OP_TRAP_EN
    logic               illegal_op;
`endif

    multicycle_control #(.ALUOP_W(ALUOP_W), .STATE_W(STATE_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .Ext(Ext),
        .PCSrc(PCSrc),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic               pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic [1:0]         reg_dst, mem_to_reg;
        logic               reg_write, alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         ext, pc_src;
        logic [STATE_W-1:0] state;
    } obs_t;

    typedef struct {
        obs_t e;
        logic ready;
    } step_t;

    typedef struct {
        string      name;
        logic [5:0] op, funct;
        int         wf, wm;
        int         cycles, reg_writes, mem_writes;
        logic [4:0] exec_alu;
    } vec_t;

    step_t      q[$];
    vec_t       vecs[$];
    logic [4:0] ref_alu[64];

    // Reference funct table, built from the list of R-type instructions
    function automatic void buildAluTable();
        logic [5:0] f[16] = '{F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU,
                              F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU};
        logic [4:0] a[16] = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_ADDU,
                              ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};
        for (int i = 0; i < 64; i++) ref_alu[i] = ALU_NOP;
        for (int i = 0; i < 16; i++) ref_alu[f[i]] = a[i];
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.pc_write = PCWrite;   o.pc_write_cond = PCWriteCond; o.iord = IorD;
        o.mem_read = MemRead;   o.mem_write = MemWrite;        o.ir_write = IRWrite;
        o.reg_dst = RegDst;     o.mem_to_reg = MemtoReg;       o.reg_write = RegWrite;
        o.alu_src_a = ALUSrcA;  o.alu_src_b = ALUSrcB;         o.alu_op = ALUop;
        o.ext = Ext;            o.pc_src = PCSrc;              o.state = state_o;
        return o;
    endfunction

    function automatic obs_t idle(input state_t st);
        obs_t o = '0;
        o.state = STATE_W'(st);
        return o;
    endfunction

    function automatic obs_t fetchRec(input logic rdy);
        obs_t o = idle(S_FETCH);
        o.mem_read = 1'b1; o.alu_src_b = 2'd1; o.alu_op = ALUOP_W'(ALU_ADD);
        o.pc_write = rdy;  o.ir_write = rdy;
        return o;
    endfunction

    function automatic void push(input obs_t e, input logic rdy);
        step_t s;
        s.e = e; s.ready = rdy;
        q.push_back(s);
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // Fetch (with wf not-ready cycles) and decode steps common to every instruction
    function automatic void modelFetchDecode(input int wf);
        obs_t e;
        for (int i = 0; i < wf; i++) push(fetchRec(1'b0), 1'b0);
        push(fetchRec(1'b1), 1'b1);
        e = idle(S_DECODE);
        e.alu_src_b = 2'd3; e.ext = EXT_SIGNED; e.alu_op = ALUOP_W'(ALU_ADD);
        push(e, rnd());
    endfunction

    // Steps after decode, per instruction class
    function automatic void modelExec(input logic [5:0] o_op, input logic [5:0] o_fn, input int wm);
        obs_t e;
        case (o_op)
            R_OP: begin
                e = idle(S_EXEC_R); e.alu_src_a = 1'b1; e.alu_op = ALUOP_W'(ref_alu[o_fn]); push(e, rnd());
                e = idle(S_WB_R);   e.reg_dst = 2'd1; e.reg_write = 1'b1;                 push(e, rnd());
            end
            ADDI_OP: begin
                e = idle(S_EXEC_I); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.ext = EXT_SIGNED;
                e.alu_op = ALUOP_W'(ALU_ADD); push(e, rnd());
                e = idle(S_WB_I); e.reg_write = 1'b1; push(e, rnd());
            end
            LW_OP, SW_OP: begin
                e = idle(S_MEM_ADDR); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.ext = EXT_SIGNED;
                e.alu_op = ALUOP_W'(ALU_ADD); push(e, rnd());
                if (o_op == LW_OP) begin
                    e = idle(S_MEM_RD); e.mem_read = 1'b1; e.iord = 1'b1;
                end else begin
                    e = idle(S_MEM_WR); e.mem_write = 1'b1; e.iord = 1'b1;
                end
                for (int i = 0; i < wm; i++) push(e, 1'b0);
                push(e, 1'b1);
                if (o_op == LW_OP) begin
                    e = idle(S_WB_MEM); e.mem_to_reg = 2'd1; e.reg_write = 1'b1; push(e, rnd());
                end
            end
            BEQ_OP: begin
                e = idle(S_BRANCH); e.alu_src_a = 1'b1; e.alu_op = ALUOP_W'(ALU_SUB);
                e.pc_write_cond = 1'b1; e.pc_src = NPC_BRANCH; push(e, rnd());
            end
            J_OP: begin
                e = idle(S_JUMP); e.pc_write = 1'b1; e.pc_src = NPC_JUMP; push(e, rnd());
            end
            JAL_OP: begin
                e = idle(S_JAL); e.pc_write = 1'b1; e.pc_src = NPC_JAL; e.reg_write = 1'b1;
                e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; push(e, rnd());
            end
            default: ;
        endcase
    endfunction

    task automatic applyStimulus(input logic [5:0] a_op, input logic [5:0] a_fn, input logic rdy);
        op = a_op; funct = a_fn; mem_ready = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Plays the model queue; entered and left just after a rising edge
    task automatic runQueue(input string tag, input logic [5:0] r_op, input logic [5:0] r_fn);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            applyStimulus(r_op, r_fn, s.ready);
            #4;
            checkOutput(tag, 64'(observe()), 64'(s.e));
`ifdef ILLEGAL_OP_TRAP_EN
            checkOutput({tag, " illegal_op"}, 64'(illegal_op), 64'd0);
`endif
            @(posedge clk); #1;
        end
    endtask

    // Runs one table vector, holding mem_ready low for the requested number
    // of cycles in FETCH and in the memory phase, and tallies the outcome.
    task automatic runVector(input vec_t v);
        int                 cycles = 0, rw = 0, mwr = 0, fw = v.wf, mw = v.wm;
        logic [4:0]         alu = ALU_NOP;
        logic [STATE_W-1:0] st, prev;
        logic               rdy;
        logic               done = 1'b0;
        prev = STATE_W'(S_FETCH);
        while (!done && cycles < 40) begin
            st  = state_o;
            rdy = 1'b1;
            if (st == STATE_W'(S_FETCH) && fw > 0) begin
                rdy = 1'b0; fw--;
            end else if ((st == STATE_W'(S_MEM_RD) || st == STATE_W'(S_MEM_WR)) && mw > 0) begin
                rdy = 1'b0; mw--;
            end
            applyStimulus(v.op, v.funct, rdy);
            #4;
            if (prev == STATE_W'(S_DECODE)) alu = 5'(ALUop);
            rw  += int'(RegWrite);
            mwr += int'(MemWrite);
            cycles++;
            prev = st;
            @(posedge clk); #1;
            if (state_o == STATE_W'(S_FETCH) && prev != STATE_W'(S_FETCH)) done = 1'b1;
        end
        checkOutput({v.name, " completes"}, 64'(done), 64'd1);
        checkOutput({v.name, " cycles"}, 64'(cycles), 64'(v.cycles));
        checkOutput({v.name, " RegWrite cycles"}, 64'(rw), 64'(v.reg_writes));
        checkOutput({v.name, " MemWrite cycles"}, 64'(mwr), 64'(v.mem_writes));
        checkOutput({v.name, " exec ALUop"}, 64'(alu), 64'(v.exec_alu));
    endtask

    function automatic void addVec(input string n, input logic [5:0] o, input logic [5:0] f,
                                   input int wf, input int wm, input int cyc, input int rw,
                                   input int mwr, input logic [4:0] alu);
        vec_t v;
        v.name = n; v.op = o; v.funct = f; v.wf = wf; v.wm = wm;
        v.cycles = cyc; v.reg_writes = rw; v.mem_writes = mwr; v.exec_alu = alu;
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        obs_t       e;
        logic [5:0] ops[8] = '{R_OP, ADDI_OP, LW_OP, SW_OP, BEQ_OP, J_OP, JAL_OP, 6'h3F};
        logic [5:0] r_op, r_fn;
        int         n_ops;

        buildAluTable();
        //            name          op       funct   wf wm cyc rw mw exec ALUop
        addVec("add",        R_OP,    F_ADD,  0, 0, 4,  1, 0, ALU_ADD);
        addVec("sub",        R_OP,    F_SUB,  0, 1, 4,  1, 0, ALU_SUB);
        addVec("sllv wait2", R_OP,    F_SLLV, 2, 0, 6,  1, 0, ALU_SLL);
        addVec("srav",       R_OP,    F_SRAV, 0, 0, 4,  1, 0, ALU_SRA);
        addVec("addi",       ADDI_OP, 6'h15,  0, 0, 4,  1, 0, ALU_ADD);
        addVec("lw mwait2",  LW_OP,   6'h00,  0, 2, 7,  1, 0, ALU_ADD);
        addVec("lw both1",   LW_OP,   6'h00,  1, 1, 7,  1, 0, ALU_ADD);
        addVec("sw fwait1",  SW_OP,   6'h00,  1, 0, 5,  0, 1, ALU_ADD);
        addVec("sw mwait3",  SW_OP,   6'h00,  0, 3, 7,  0, 4, ALU_ADD);
        addVec("beq",        BEQ_OP,  6'h00,  0, 0, 3,  0, 0, ALU_SUB);
        addVec("j",          J_OP,    6'h00,  0, 0, 3,  0, 0, ALU_NOP);
        addVec("jal",        JAL_OP,  6'h00,  0, 0, 3,  1, 0, ALU_NOP);
`ifndef ILLEGAL_OP_TRAP_EN
        addVec("r bad funct", R_OP,   6'h3F,  0, 0, 4,  1, 0, ALU_NOP);
        addVec("op 0x3F",    6'h3F,   6'h00,  0, 0, 2,  0, 0, ALU_NOP);
`endif

        // Reset: outputs quiet while rst_n is low, even with mem_ready high
        rst_n = 1'b0;
        applyStimulus(6'h00, 6'h00, 1'b0);
        #3;
        checkOutput("reset outputs", 64'(observe()), 64'(idle(S_FETCH)));
        mem_ready = 1'b1;
        #1;
        checkOutput("reset gates mem_ready", 64'(observe()), 64'(idle(S_FETCH)));
        @(posedge clk); #3;
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        checkOutput("fetch after reset", 64'(observe()), 64'(fetchRec(1'b0)));
        @(posedge clk); #1;

        $display("[TB] table vectors");
        foreach (vecs[i]) runVector(vecs[i]);

        // Exact per-cycle strobes of the test-plan instructions
        $display("[TB] directed sequences");
        modelFetchDecode(0); modelExec(R_OP, F_ADD, 0);  runQueue("seq add", R_OP, F_ADD);
        modelFetchDecode(0); modelExec(LW_OP, 0, 2);     runQueue("seq lw", LW_OP, 6'h00);
        modelFetchDecode(1); modelExec(SW_OP, 0, 0);     runQueue("seq sw", SW_OP, 6'h00);
        modelFetchDecode(0); modelExec(JAL_OP, 0, 0);    runQueue("seq jal", JAL_OP, 6'h00);

        // Reset while a store is waiting on memory
        applyStimulus(SW_OP, 6'h00, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        applyStimulus(SW_OP, 6'h00, 1'b0);
        #2;
        e = idle(S_MEM_WR); e.mem_write = 1'b1; e.iord = 1'b1;
        checkOutput("mem_wr waiting", 64'(observe()), 64'(e));
        rst_n = 1'b0;
        #1;
        checkOutput("reset in mem_wr", 64'(observe()), 64'(idle(S_FETCH)));
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        checkOutput("fetch after mid-reset", 64'(observe()), 64'(fetchRec(1'b0)));
        @(posedge clk); #1;

        // Unlisted opcode / unknown funct
`ifdef ILLEGAL_OP_TRAP_EN
        for (int k = 0; k < 2; k++) begin
            r_op = (k == 0) ? 6'h3F : R_OP;
            r_fn = 6'h3F;
            modelFetchDecode(0);
            runQueue("trap entry", r_op, r_fn);
            for (int c = 0; c < 3; c++) begin
                applyStimulus(r_op, r_fn, rnd());
                #4;
                checkOutput("trap outputs", 64'(observe()), 64'(idle(S_TRAP)));
                checkOutput("trap illegal_op", 64'(illegal_op), 64'd1);
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            mem_ready = 1'b0;
            #1;
            checkOutput("trap cleared by reset", 64'(illegal_op), 64'd0);
            @(posedge clk); #3;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end
        n_ops = 7;
`else
        modelFetchDecode(0); modelExec(6'h3F, 0, 0);     runQueue("seq op 0x3F", 6'h3F, 6'h00);
        n_ops = 8;
`endif

        // Randomized instruction stream against the model
        $display("[TB] random stream");
        for (int n = 0; n < 200; n++) begin
            int wf, wm;
            r_op = ops[$urandom_range(0, n_ops - 1)];
`ifdef ILLEGAL_OP_TRAP_EN
            do r_fn = 6'($urandom_range(0, 63)); while (ref_alu[r_fn] == ALU_NOP);
`else
            r_fn = 6'($urandom_range(0, 63));
`endif
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            modelFetchDecode(wf);
            modelExec(r_op, r_fn, wm);
            runQueue("random", r_op, r_fn);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over 3–5+ cycles.
- Drives datapath strobes per state, with a ready handshake to a shared instruction/data memory.
- Sits between the instruction register (op/funct) and the multi-cycle datapath (PC, IR, MDR, A/B, ALUOut).

Parameters:
- ALUOP_W, 5, width of ALUop; must hold every ALU code in the shared header.
- STATE_W, 4, state register width; must be ≥ ceil(log2(number of states)).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (branch)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load IR
- RegDst  out  2  write register: 0 = rt, 1 = rd, 2 = $31
- MemtoReg  out  2  write data: 0 = ALUOut, 1 = MDR, 2 = PC
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  0 = B, 1 = const 4, 2 = ext imm, 3 = ext imm << 2
- ALUop  out  ALUOP_W  ALU operation code
- Ext  out  2  immediate extension type (EXT_ZERO / EXT_SIGNED)
- PCSrc  out  2  NPC_PLUS4 / NPC_BRANCH / NPC_JUMP / NPC_JAL
- state_o  out  STATE_W  current state, for debug

Behaviour:
- Reset: async on rst_n low.
  - State goes to FETCH immediately, including mid-instruction.
  - Pending memory requests are abandoned.
  - While rst_n is low, all strobes are 0, ALUop = ALU_NOP, Ext = EXT_ZERO, PCSrc = NPC_PLUS4, muxes = 0.
- Outputs: default 0 / ALU_NOP in every state unless listed below. Decoded from the registered state; PCWrite and IRWrite in FETCH are additionally gated by mem_ready.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 1, ALUop = ALU_ADD, PCSrc = NPC_PLUS4.
  - If mem_ready: IRWrite = 1, PCWrite = 1, go to DECODE; else hold.
- DECODE: ALUSrcA = 0, ALUSrcB = 3, Ext = EXT_SIGNED, ALUop = ALU_ADD (precompute branch target). Next state by op:
  - R_OP → EXEC_R
  - ADDI_OP → EXEC_I
  - LW_OP or SW_OP → MEM_ADDR
  - BEQ_OP → BRANCH
  - J_OP → JUMP
  - JAL_OP → JAL
  - any other op → FETCH (treated as NOP)
- EXEC_R:
  - ALUSrcA = 1, ALUSrcB = 0, ALUop from funct via alu_decoder. SLLV/SRLV/SRAV map to SLL/SRL/SRA.
  - Unknown funct gives ALU_NOP, and the instruction still writes back.
  - Next: WB_R.
- WB_R: RegDst = 1, MemtoReg = 0, RegWrite = 1 → FETCH.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 2, Ext = EXT_SIGNED, ALUop = ALU_ADD → WB_I.
- WB_I: RegDst = 0, MemtoReg = 0, RegWrite = 1 → FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 2, Ext = EXT_SIGNED, ALUop = ALU_ADD. Next: MEM_RD if LW, MEM_WR if SW.
- MEM_RD: MemRead = 1, IorD = 1. Hold until mem_ready, then → WB_MEM.
- MEM_WR: MemWrite = 1, IorD = 1. Hold until mem_ready, then → FETCH.
- WB_MEM: RegDst = 0, MemtoReg = 1, RegWrite = 1 → FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 0, ALUop = ALU_SUB, PCWriteCond = 1, PCSrc = NPC_BRANCH → FETCH.
- JUMP: PCWrite = 1, PCSrc = NPC_JUMP → FETCH.
- JAL: PCWrite = 1, PCSrc = NPC_JAL, RegWrite = 1, RegDst = 2, MemtoReg = 2 → FETCH.
  - PC still holds PC+4 this cycle, so that is the value written to $31.
- Latency with mem_ready tied high:
  - R, ADDI, SW: 4 cycles
  - LW: 5 cycles
  - BEQ, J, JAL: 3 cycles
  - Each cycle mem_ready is low adds one cycle in FETCH, MEM_RD or MEM_WR.
- Memory handshake: request signals stay stable while waiting; there is no timeout. mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- An unreachable state encoding goes to FETCH on the next clock.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN
- Defined: adds output illegal_op (1 bit) and state TRAP.
  - An unlisted op in DECODE, or an unknown funct in DECODE with op = R_OP, goes to TRAP.
  - In TRAP, illegal_op = 1, all other strobes are 0, and the state holds until rst_n low.
- Undefined: no port and no state; unlisted ops fall through to FETCH as NOPs.

Decomposition:
- Shared header: opcode and funct codes, ALU_* codes, EXT_*, NPC_*, and state encodings (S_FETCH…S_TRAP) as defines/localparams.
- One sub-module, alu_decoder: combinational funct → ALUop lookup, reusable by a later pipelined control unit.

Test Plan:
- add (op = 0, funct = 0x20), mem_ready = 1: states FETCH, DECODE, EXEC_R, WB_R; RegWrite = 1 and RegDst = 1 only in cycle 4; ALUop = ALU_ADD in cycle 3.
- lw (op = 0x23), mem_ready low 2 cycles in MEM_RD: MemRead and IorD = 1 held 3 cycles; WB_MEM asserts MemtoReg = 1, RegWrite = 1; total 7 cycles.
- sw (op = 0x2B), mem_ready low 1 cycle in FETCH: IRWrite and PCWrite pulse only on the ready cycle; MemWrite = 1 in MEM_WR; RegWrite never 1.
- beq (0x04), j (0x02), jal (0x03): each 3 cycles. PCWriteCond = 1 with NPC_BRANCH for beq; PCWrite = 1 with NPC_JUMP for j. For jal: NPC_JAL, RegDst = 2, MemtoReg = 2, RegWrite = 1.
- rst_n low during MEM_WR: MemWrite drops to 0 asynchronously; after release, state_o = S_FETCH with MemRead = 1.
- op = 0x3F: FETCH after DECODE with no writes; with ILLEGAL_OP_TRAP_EN, TRAP is entered and illegal_op = 1 until reset.
